onehot_decoder_seq: RTL and testbench

Parametrised, registered successor to the team's 5-to-32 one-hot decoder. Accepts address commands over a valid/ready handshake and emits registered one-hot or thermometer codes over a second valid/ready handshake. Adds a sweep mode that auto-walks the one-hot bit from the given address to the top output, one beat per output handshake. Sits between a control/sequencer block and row/word-line select logic, and also serves as a built-in stimulus source for decoder self-test.

---
 rtl/onehot_decoder_seq.sv | 135 +++++++++++++
 tb/tb_onehot_decoder_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot / thermometer decoder with valid/ready on both sides and a
// sweep mode that walks the one-hot bit from the command address up to the top output.
module onehot_decoder_seq #(
    parameter int AW = 5,
    localparam int OW = 2**AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] a,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] z,
    output logic          last,
    output logic          err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_SWEEP  = 2'b01,
        MODE_THERM  = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    localparam logic [AW-1:0] TOP = AW'(OW - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [OW-1:0] z_q, z_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    logic          valid_q, valid_d;

    logic [OW-1:0] onehot_dec;
    logic [OW-1:0] therm_dec;
    logic          accept;
    logic          out_hs;

    for (genvar gi = 0; gi < OW; gi++) begin : g_dec
        assign onehot_dec[gi] = (a == AW'(gi));
        assign therm_dec[gi]  = (AW'(gi) <= a);
    end

    // SWEEP means beats remain after the one on z, so the final sweep beat
    // already runs in IDLE and a new command can replace it without a bubble.
    assign in_ready = (state_q == IDLE) && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign out_hs   = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        z_d     = z_q;
        last_d  = last_q;
        err_d   = err_q;
        valid_d = valid_q;

        if (flush) begin
            state_d = IDLE;
            ptr_d   = '0;
            z_d     = '0;
            last_d  = 1'b0;
            err_d   = 1'b0;
            valid_d = 1'b0;
        end else if (accept) begin
            state_d = IDLE;
            ptr_d   = a;
            last_d  = 1'b1;
            err_d   = 1'b0;
            valid_d = 1'b1;
            case (mode_t'(mode))
                MODE_SINGLE: z_d = onehot_dec;
                MODE_SWEEP: begin
                    z_d = onehot_dec;
                    if (a != TOP) begin
                        state_d = SWEEP;
                        last_d  = 1'b0;
                    end
                end
                MODE_THERM: z_d = therm_dec;
                default: begin
                    z_d   = '0;
                    err_d = 1'b1;
                end
            endcase
        end else if (out_hs) begin
            if (state_q == SWEEP) begin
                // ptr_q < TOP here, so the increment never wraps.
                ptr_d  = ptr_q + AW'(1);
                z_d    = z_q << 1;
                last_d = (ptr_d == TOP);
                if (ptr_d == TOP) begin
                    state_d = IDLE;
                end
            end else begin
                z_d     = '0;
                last_d  = 1'b0;
                err_d   = 1'b0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            z_q     <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            z_q     <= z_d;
            last_q  <= last_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign z         = z_q;
    assign last      = last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: beat-queue reference model checked every cycle,
// directed literal checks, randomized traffic, plus a small AW=3 instance.
module tb_onehot_decoder_seq;

    localparam int AW = 5;
    localparam int OW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] a = '0;
    logic [1:0]    mode = '0;
    logic          in_ready, out_valid, last, err;
    logic [OW-1:0] z;

    logic          s_flush = 1'b0;
    logic          s_in_valid = 1'b0;
    logic          s_out_ready = 1'b0;
    logic [2:0]    s_a = '0;
    logic [1:0]    s_mode = '0;
    logic          s_in_ready, s_out_valid, s_last, s_err;
    logic [7:0]    s_z;

    int n_checks = 0;
    int n_errors = 0;

    logic [OW-1:0] sw28 [4];

    always #5 clk = ~clk;

    onehot_decoder_seq #(.AW(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .last(last), .err(err)
    );

    onehot_decoder_seq #(.AW(3)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .mode(s_mode),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .z(s_z), .last(s_last), .err(s_err)
    );

    // Reference: the queue holds every beat of the current command still to be delivered.
    typedef struct packed {
        logic [OW-1:0] z;
        logic          last;
        logic          err;
    } beat_t;

    beat_t exp_q[$];

    function automatic bit model_ready();
        return (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
    endfunction

    function automatic void push_cmd(input logic [AW-1:0] ca, input logic [1:0] cm);
        beat_t b;
        b = '0;
        b.last = 1'b1;
        case (cm)
            2'b00: begin
                b.z[ca] = 1'b1;
                exp_q.push_back(b);
            end
            2'b10: begin
                for (int i = 0; i <= int'(ca); i++) b.z[i] = 1'b1;
                exp_q.push_back(b);
            end
            2'b11: begin
                b.err = 1'b1;
                exp_q.push_back(b);
            end
            default: begin
                for (int i = int'(ca); i < OW; i++) begin
                    b.z    = '0;
                    b.z[i] = 1'b1;
                    b.last = (i == OW - 1);
                    exp_q.push_back(b);
                end
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_p
        bit acc;
        if (!rst_n) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else begin
            acc = in_valid && model_ready();
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (acc) push_cmd(a, mode);
        end
    end

    always @(negedge clk) begin : compare_p
        logic          e_v, e_l, e_e, e_r;
        logic [OW-1:0] e_z;
        e_v = (exp_q.size() != 0);
        e_z = e_v ? exp_q[0].z : '0;
        e_l = e_v ? exp_q[0].last : 1'b0;
        e_e = e_v ? exp_q[0].err : 1'b0;
        e_r = model_ready();
        n_checks++;
        if ({out_valid, z, last, err, in_ready} !== {e_v, e_z, e_l, e_e, e_r}) begin
            n_errors++;
            $display("FAIL cycle_cmp t=%0t: got v=%b z=%h last=%b err=%b rdy=%b, expected v=%b z=%h last=%b err=%b rdy=%b",
                     $time, out_valid, z, last, err, in_ready, e_v, e_z, e_l, e_e, e_r);
        end
        if (out_valid && out_ready)
            $display("beat t=%0t z=%h last=%b err=%b", $time, z, last, err);
    end

    task automatic pin(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sw28[0] = 32'h1000_0000;
        sw28[1] = 32'h2000_0000;
        sw28[2] = 32'h4000_0000;
        sw28[3] = 32'h8000_0000;

        #12;
        pin("rst_valid", out_valid, 0);
        pin("rst_z", z, 0);
        pin("rst_last", last, 0);
        pin("rst_err", err, 0);
        pin("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Exhaustive single mode, back-to-back.
        in_valid = 1; mode = 2'b00; out_ready = 1;
        for (int i = 0; i < OW; i++) begin
            a = AW'(i);
            tick();
            pin("single_z", z, 64'(1) << i);
            pin("single_last", last, 1);
            pin("single_err", err, 0);
        end
        pin("single_top", z, 32'h8000_0000);
        in_valid = 0;
        tick();
        pin("idle_valid", out_valid, 0);
        pin("idle_z", z, 0);

        // Sweep near the top with free-running consumer.
        in_valid = 1; mode = 2'b01; a = 28;
        tick();
        in_valid = 0;
        for (int b = 0; b < 4; b++) begin
            pin("sweep28_z", z, sw28[b]);
            pin("sweep28_last", last, (b == 3));
            pin("sweep28_rdy", in_ready, (b == 3));
            tick();
        end
        pin("sweep28_done", out_valid, 0);

        // Sweep with a stall, then a=31 accepted on the final beat's handshake.
        in_valid = 1; mode = 2'b01; a = 30;
        tick();
        in_valid = 0; out_ready = 0;
        pin("stall_z0", z, 32'h4000_0000);
        tick();
        pin("stall_hold1", z, 32'h4000_0000);
        pin("stall_rdy", in_ready, 0);
        tick();
        pin("stall_hold2", z, 32'h4000_0000);
        pin("stall_last", last, 0);
        out_ready = 1;
        tick();
        pin("stall_top_z", z, 32'h8000_0000);
        pin("stall_top_last", last, 1);
        in_valid = 1; a = 31;
        tick();
        in_valid = 0;
        pin("sweep31_z", z, 32'h8000_0000);
        pin("sweep31_last", last, 1);
        pin("sweep31_valid", out_valid, 1);
        tick();
        pin("sweep31_done", out_valid, 0);

        // Thermometer, reserved, then single shows err cleared.
        in_valid = 1; mode = 2'b10; a = 3;
        tick();
        pin("therm_z", z, 32'h0000_000F);
        pin("therm_last", last, 1);
        mode = 2'b11; a = 7;
        tick();
        pin("rsvd_z", z, 0);
        pin("rsvd_err", err, 1);
        pin("rsvd_last", last, 1);
        mode = 2'b00; a = 1;
        tick();
        pin("after_rsvd_z", z, 32'h2);
        pin("after_rsvd_err", err, 0);
        in_valid = 0;
        tick();

        // Flush during beat 5 of a full sweep; presented command is dropped.
        in_valid = 1; mode = 2'b01; a = 0;
        tick();
        in_valid = 0;
        repeat (4) tick();
        pin("flush_pre_z", z, 32'h10);
        flush = 1; in_valid = 1; mode = 2'b00; a = 3;
        tick();
        flush = 0; in_valid = 0;
        pin("flush_valid", out_valid, 0);
        pin("flush_z", z, 0);
        pin("flush_rdy", in_ready, 1);
        in_valid = 1; mode = 2'b00; a = 9;
        tick();
        pin("post_flush_z", z, 32'h200);
        flush = 1; a = 4;
        tick();
        flush = 0; in_valid = 0;
        pin("flush_idle_valid", out_valid, 0);
        tick();

        // Asynchronous reset mid-sweep.
        in_valid = 1; mode = 2'b01; a = 10;
        tick();
        in_valid = 0;
        repeat (3) tick();
        pin("pre_rst_z", z, 32'h2000);
        #2 rst_n = 1'b0;
        #1;
        pin("arst_z", z, 0);
        pin("arst_valid", out_valid, 0);
        pin("arst_rdy", in_ready, 1);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            pin("post_rst_valid", out_valid, 0);
        end

        // AW=3 instance: OW=8 parametrisation.
        s_out_ready = 1; s_in_valid = 1; s_mode = 2'b01; s_a = 5;
        tick();
        s_in_valid = 0;
        pin("small_sw_z0", s_z, 8'h20);
        pin("small_sw_l0", s_last, 0);
        tick();
        pin("small_sw_z1", s_z, 8'h40);
        tick();
        pin("small_sw_z2", s_z, 8'h80);
        pin("small_sw_l2", s_last, 1);
        tick();
        pin("small_sw_done", s_out_valid, 0);
        s_in_valid = 1; s_mode = 2'b10; s_a = 2;
        tick();
        pin("small_therm_z", s_z, 8'h07);
        s_mode = 2'b00; s_a = 7;
        tick();
        pin("small_single_z", s_z, 8'h80);
        s_in_valid = 0;
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = AW'($urandom);
            mode      = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            if (mode == 2'b01 && $urandom_range(0, 3) != 0)
                a = AW'(OW - 1 - int'($urandom_range(0, 4)));
            tick();
        end
        flush = 0; in_valid = 0; out_ready = 1;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
